// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line payloads, arbiter state and grant encodings.
package lc3b_types;

  localparam int unsigned WORD_W         = 16;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned CONFLICT_CNT_W = 16;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_cache_line;

  // L2 arbiter/scheduler states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  // Which requester owns (or last owned) the L2 port
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_e;

  // Latched L2 request; drives the l2_mem_* outputs directly
  typedef struct packed {
    lc3b_word       addr;
    logic           read;
    logic           write;
    lc3b_cache_line wdata;
  } l2_req_t;

endpackage

// File: rtl/l2_arb_sched.sv
// l2_arb_sched: arbitrates i-cache and d-cache line requests onto a single L2 port.
// Alternating priority on ties, one transaction in flight, latched L2 request,
// one-cycle completion pulse per requester, saturating contention counter.
// Ports:
//   clk, reset_n                         clock, synchronous active-low reset
//   i_mem_address/read                   i-cache line-read request
//   i_mem_rdata/resp                     i-cache return line and completion pulse
//   d_mem_address/read/write/wdata       d-cache request
//   d_mem_rdata/resp                     d-cache return line and completion pulse
//   l2_mem_address/read/write/wdata      L2 request (registered)
//   l2_mem_rdata/resp                    L2 return line and completion
//   arb_conflict_count                   saturating count of contended grants
module l2_arb_sched
  import lc3b_types::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  lc3b_word                  i_mem_address,
  input  logic                      i_mem_read,
  output lc3b_cache_line            i_mem_rdata,
  output logic                      i_mem_resp,
  input  lc3b_word                  d_mem_address,
  input  logic                      d_mem_read,
  input  logic                      d_mem_write,
  input  lc3b_cache_line            d_mem_wdata,
  output lc3b_cache_line            d_mem_rdata,
  output logic                      d_mem_resp,
  output lc3b_word                  l2_mem_address,
  output logic                      l2_mem_read,
  output logic                      l2_mem_write,
  output lc3b_cache_line            l2_mem_wdata,
  input  lc3b_cache_line            l2_mem_rdata,
  input  logic                      l2_mem_resp,
  output logic [CONFLICT_CNT_W-1:0] arb_conflict_count
);

  arb_state_e                state_q, state_d;
  arb_grant_e                last_grant_q, last_grant_d;
  l2_req_t                   req_q, req_d;
  lc3b_cache_line            i_rdata_q, i_rdata_d;
  lc3b_cache_line            d_rdata_q, d_rdata_d;
  logic                      i_resp_q, i_resp_d;
  logic                      d_resp_q, d_resp_d;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic i_req_c;
  logic d_req_c;
  logic grant_i_c;

  // Request decode and tie-break: on contention the side not granted last time wins
  always_comb begin
    i_req_c   = i_mem_read;
    d_req_c   = d_mem_read | d_mem_write;
    grant_i_c = i_req_c && (!d_req_c || (last_grant_q == GRANT_D));
  end

  // Next-state and next-register logic
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    req_d          = req_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    i_resp_d       = 1'b0;
    d_resp_d       = 1'b0;
    conflict_cnt_d = conflict_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_req_c || d_req_c) begin
          if (i_req_c && d_req_c && (conflict_cnt_q != {CONFLICT_CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CONFLICT_CNT_W'(1);
          end
          if (grant_i_c) begin
            state_d      = SERVE_I;
            last_grant_d = GRANT_I;
            req_d.addr   = i_mem_address;
            req_d.read   = 1'b1;
            req_d.write  = 1'b0;
            req_d.wdata  = '0;
          end else begin
            // a simultaneous read+write from the d-cache is treated as a write
            state_d      = SERVE_D;
            last_grant_d = GRANT_D;
            req_d.addr   = d_mem_address;
            req_d.read   = ~d_mem_write;
            req_d.write  = d_mem_write;
            req_d.wdata  = d_mem_write ? d_mem_wdata : '0;
          end
        end
      end

      SERVE_I, SERVE_D: begin
        if (l2_mem_resp) begin
          state_d     = RESP;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
          req_d.wdata = '0;
          if (state_q == SERVE_I) begin
            i_resp_d  = 1'b1;
            i_rdata_d = l2_mem_rdata;
          end else begin
            d_resp_d  = 1'b1;
            if (req_q.read) begin
              d_rdata_d = l2_mem_rdata;
            end
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_D;
      req_q          <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      req_q          <= req_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      i_resp_q       <= i_resp_d;
      d_resp_q       <= d_resp_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign l2_mem_address     = req_q.addr;
  assign l2_mem_read        = req_q.read;
  assign l2_mem_write       = req_q.write;
  assign l2_mem_wdata       = req_q.wdata;
  assign i_mem_rdata        = i_rdata_q;
  assign i_mem_resp         = i_resp_q;
  assign d_mem_rdata        = d_rdata_q;
  assign d_mem_resp         = d_resp_q;
  assign arb_conflict_count = conflict_cnt_q;

endmodule

// File: tb/tb_l2_arb_sched.sv
// Testbench for l2_arb_sched: transaction-level model checked every cycle, an L2
// responder with programmable latency, and directed scenarios with literal pins.
module tb_l2_arb_sched;
  import lc3b_types::*;

  logic           clk = 1'b0;
  logic           reset_n;
  lc3b_word       i_mem_address;
  logic           i_mem_read;
  lc3b_cache_line i_mem_rdata;
  logic           i_mem_resp;
  lc3b_word       d_mem_address;
  logic           d_mem_read;
  logic           d_mem_write;
  lc3b_cache_line d_mem_wdata;
  lc3b_cache_line d_mem_rdata;
  logic           d_mem_resp;
  lc3b_word       l2_mem_address;
  logic           l2_mem_read;
  logic           l2_mem_write;
  lc3b_cache_line l2_mem_wdata;
  lc3b_cache_line l2_mem_rdata;
  logic           l2_mem_resp;
  logic [15:0]    arb_conflict_count;

  always #5 clk = ~clk;

  l2_arb_sched dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_mem_address      (i_mem_address),
    .i_mem_read         (i_mem_read),
    .i_mem_rdata        (i_mem_rdata),
    .i_mem_resp         (i_mem_resp),
    .d_mem_address      (d_mem_address),
    .d_mem_read         (d_mem_read),
    .d_mem_write        (d_mem_write),
    .d_mem_wdata        (d_mem_wdata),
    .d_mem_rdata        (d_mem_rdata),
    .d_mem_resp         (d_mem_resp),
    .l2_mem_address     (l2_mem_address),
    .l2_mem_read        (l2_mem_read),
    .l2_mem_write       (l2_mem_write),
    .l2_mem_wdata       (l2_mem_wdata),
    .l2_mem_rdata       (l2_mem_rdata),
    .l2_mem_resp        (l2_mem_resp),
    .arb_conflict_count (arb_conflict_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [127:0] BASE = {8{16'hA5A5}};

  // L2 responder: answers after l2_lat cycles of a visible request; each answer
  // carries BASE ^ sequence number so captures can be told apart.
  int   l2_lat  = 3;
  int   seen    = 0;
  int   resp_no = 0;
  logic l2_hit  = 1'b0;
  logic stray   = 1'b0;
  assign l2_mem_resp = l2_hit | stray;

  always @(negedge clk) begin
    if (!(l2_mem_read || l2_mem_write)) begin
      seen   = 0;
      l2_hit = 1'b0;
    end else begin
      seen++;
      if (seen == l2_lat) begin
        l2_hit       = 1'b1;
        l2_mem_rdata = BASE ^ 128'(resp_no);
        resp_no++;
      end else begin
        l2_hit = 1'b0;
      end
    end
  end

  // Transaction-level model: one outstanding transaction record plus a resp cycle
  bit             m_live = 0;
  bit             m_busy, m_resp_cyc, m_side_d, m_wr, m_last_i;
  lc3b_word       m_addr;
  lc3b_cache_line m_wdata, m_i_line, m_d_line;
  int             m_conflicts;
  int             cnt_offset = 0;

  always @(posedge clk) begin : model
    bit ir, dr, take_i;
    if (!reset_n) begin
      m_live = 1; m_busy = 0; m_resp_cyc = 0; m_side_d = 0; m_wr = 0;
      m_last_i = 0; m_addr = '0; m_wdata = '0; m_i_line = '0; m_d_line = '0;
      m_conflicts = 0;
    end else if (m_live) begin
      if (m_resp_cyc) begin
        m_resp_cyc = 0;
      end else if (m_busy) begin
        if (l2_mem_resp) begin
          m_busy = 0;
          m_resp_cyc = 1;
          if (!m_wr) begin
            if (m_side_d) m_d_line = l2_mem_rdata;
            else          m_i_line = l2_mem_rdata;
          end
        end
      end else begin
        ir = i_mem_read;
        dr = d_mem_read | d_mem_write;
        if (ir || dr) begin
          take_i = ir && !(dr && m_last_i);
          if (ir && dr) m_conflicts++;
          m_busy   = 1;
          m_side_d = !take_i;
          m_last_i = take_i;
          if (take_i) begin
            m_wr = 0; m_addr = i_mem_address; m_wdata = '0;
          end else begin
            m_wr = d_mem_write; m_addr = d_mem_address;
            m_wdata = d_mem_write ? d_mem_wdata : '0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    int e_cnt;
    if (m_live) begin
      e_cnt = m_conflicts + cnt_offset;
      if (e_cnt > 65535) e_cnt = 65535;
      check("l2_read",  l2_mem_read,  m_busy && !m_wr);
      check("l2_write", l2_mem_write, m_busy && m_wr);
      check("l2_addr",  l2_mem_address, m_addr);
      check("l2_wdata", l2_mem_wdata, (m_busy && m_wr) ? m_wdata : '0);
      check("i_resp",   i_mem_resp, m_resp_cyc && !m_side_d);
      check("d_resp",   d_mem_resp, m_resp_cyc && m_side_d);
      check("i_rdata",  i_mem_rdata, m_i_line);
      check("d_rdata",  d_mem_rdata, m_d_line);
      check("conflict_cnt", arb_conflict_count, 128'(e_cnt));
    end
  end

  // Wait (bounded) for a resp pulse on one side; cyc = negedges elapsed
  task automatic wait_resp(input bit want_d, output int cyc);
    bit got = 0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (want_d ? d_mem_resp : i_mem_resp) got = 1;
    end
    check(want_d ? "d_resp_arrives" : "i_resp_arrives", got, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    i_mem_read = 0; d_mem_read = 0; d_mem_write = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int cyc;
    int d_seen;
    reset_n = 1'b0;
    i_mem_address = '0; i_mem_read = 0;
    d_mem_address = '0; d_mem_read = 0; d_mem_write = 0; d_mem_wdata = '0;
    l2_mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_l2_read", l2_mem_read, 1'b0);
    check("rst_cnt", arb_conflict_count, 16'h0000);
    reset_n = 1'b1;

    // single i-cache read, L2 latency 3
    @(negedge clk);
    l2_lat = 3; i_mem_address = 16'h1230; i_mem_read = 1;
    @(negedge clk);
    check("s1_l2_read_n1", l2_mem_read, 1'b1);
    check("s1_l2_addr", l2_mem_address, 16'h1230);
    i_mem_read = 0;
    wait_resp(0, cyc);
    check("s1_latency", cyc, 3);
    check("s1_i_rdata", i_mem_rdata, BASE);
    check("s1_d_resp", d_mem_resp, 1'b0);
    check("s1_d_rdata", d_mem_rdata, 128'h0);
    @(negedge clk);
    check("s1_i_resp_one_cycle", i_mem_resp, 1'b0);

    // minimum request-to-resp latency
    l2_lat = 1; i_mem_address = 16'h0002; i_mem_read = 1;
    wait_resp(0, cyc);
    i_mem_read = 0;
    check("min_latency", cyc, 2);
    check("min_i_rdata", i_mem_rdata, BASE ^ 128'd1);

    // tie from reset: I first, then D
    do_reset();
    l2_lat = 2;
    i_mem_address = 16'h1111; i_mem_read = 1;
    d_mem_address = 16'h2222; d_mem_read = 1;
    wait_resp(0, cyc);
    i_mem_read = 0;
    wait_resp(1, cyc);
    d_mem_read = 0;
    check("s2_cnt", arb_conflict_count, 16'd1);
    check("s2_i_rdata", i_mem_rdata, BASE ^ 128'd2);
    check("s2_d_rdata", d_mem_rdata, BASE ^ 128'd3);

    // back-to-back ties alternate I,D,I,D
    do_reset();
    i_mem_read = 1; d_mem_read = 1;
    for (int k = 0; k < 4; k++) wait_resp(k[0], cyc);
    i_mem_read = 0; d_mem_read = 0;
    check("s3_cnt", arb_conflict_count, 16'd4);

    // d write; requester address/data change mid-transaction is ignored
    @(negedge clk);
    l2_lat = 4; d_mem_address = 16'h0040; d_mem_wdata = {8{16'hDEAD}}; d_mem_write = 1;
    @(negedge clk);
    check("s4_l2_write", l2_mem_write, 1'b1);
    check("s4_l2_read", l2_mem_read, 1'b0);
    check("s4_l2_wdata", l2_mem_wdata, {8{16'hDEAD}});
    d_mem_address = 16'h0080; d_mem_wdata = {8{16'hBEEF}}; d_mem_write = 0;
    @(negedge clk);
    check("s4_addr_held", l2_mem_address, 16'h0040);
    check("s4_wdata_held", l2_mem_wdata, {8{16'hDEAD}});
    wait_resp(1, cyc);
    check("s4_d_rdata_kept", d_mem_rdata, BASE ^ 128'd7);

    // read+write together: write wins
    @(negedge clk);
    l2_lat = 1; d_mem_address = 16'h0100; d_mem_wdata = {8{16'h1234}};
    d_mem_read = 1; d_mem_write = 1;
    @(negedge clk);
    check("rw_write_wins", l2_mem_write, 1'b1);
    check("rw_no_read", l2_mem_read, 1'b0);
    d_mem_read = 0; d_mem_write = 0;
    wait_resp(1, cyc);
    check("rw_d_rdata_kept", d_mem_rdata, BASE ^ 128'd7);

    // reset in SERVE_D abandons the transaction
    @(negedge clk);
    l2_lat = 10; d_mem_address = 16'h0200; d_mem_read = 1;
    @(negedge clk);
    check("s5_serving", l2_mem_read, 1'b1);
    d_mem_read = 0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("s5_l2_read_off", l2_mem_read, 1'b0);
    check("s5_l2_addr_zero", l2_mem_address, 16'h0000);
    check("s5_d_rdata_zero", d_mem_rdata, 128'h0);
    check("s5_i_rdata_zero", i_mem_rdata, 128'h0);
    reset_n = 1'b1;
    d_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (d_mem_resp) d_seen++;
      stray = (k == 3);
    end
    stray = 1'b0;
    check("s5_no_d_resp", d_seen, 0);
    l2_lat = 2; i_mem_address = 16'h3000; i_mem_read = 1;
    wait_resp(0, cyc);
    i_mem_read = 0;
    check("s5_i_latency", cyc, 3);
    check("s5_i_rdata", i_mem_rdata, BASE ^ 128'd10);

    // conflict counter saturation: preload near the top, then force ties
    @(posedge clk);
    #1;
    dut.conflict_cnt_q = 16'hFFFC;
    cnt_offset = 65532;
    @(negedge clk);
    l2_lat = 1; i_mem_read = 1; d_mem_read = 1;
    for (int k = 0; k < 6; k++) begin
      wait_resp(!k[0], cyc);
      if (k == 2) check("sat_reach", arb_conflict_count, 16'hFFFF);
    end
    i_mem_read = 0; d_mem_read = 0;
    repeat (3) @(negedge clk);
    check("sat_hold", arb_conflict_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_arb_sched.md
L2_ARB_SCHED -- requirements
Module: l2_arb_sched

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-003 SHALL have port i_mem_address, input, lc3b_word: i-cache line address.
REQ-004 SHALL have port i_mem_read, input, 1: i-cache line-read request.
REQ-005 SHALL have port i_mem_rdata, output, lc3b_cache_line: line returned to the i-cache.
REQ-006 SHALL have port i_mem_resp, output, 1: one-cycle i-cache completion pulse.
REQ-007 SHALL have ports d_mem_address (input, lc3b_word), d_mem_read (input, 1), d_mem_write (input, 1) and d_mem_wdata (input, lc3b_cache_line): d-cache request.
REQ-008 SHALL have ports d_mem_rdata (output, lc3b_cache_line) and d_mem_resp (output, 1): d-cache return data and completion pulse.
REQ-009 SHALL have ports l2_mem_address (output, lc3b_word), l2_mem_read (output, 1), l2_mem_write (output, 1) and l2_mem_wdata (output, lc3b_cache_line): L2 request.
REQ-010 SHALL have ports l2_mem_rdata (input, lc3b_cache_line) and l2_mem_resp (input, 1): L2 return data and completion.
REQ-011 SHALL have port arb_conflict_count, output, 16: saturating count of contended grants.

Function
REQ-012 SHALL implement the states IDLE, SERVE_I, SERVE_D and RESP.
REQ-013 In IDLE, a request SHALL be i_mem_read, or d_mem_read|d_mem_write.
- One requester active: grant it.
- Both active: grant the requester not recorded in last_grant.
- Neither active: remain in IDLE.
REQ-014 On grant, the block SHALL latch address, operation and wdata, update last_grant, and move to SERVE_I or SERVE_D.
REQ-015 While the block is in SERVE_x, l2_mem_* SHALL be driven only from the latched registers; requester input changes SHALL be ignored until the next IDLE.
REQ-016 Only SERVE_x SHALL assert l2_mem_read or l2_mem_write, and only one of them at a time; both SHALL be 0 in IDLE and RESP.
REQ-017 If d_mem_read and d_mem_write are both high at grant, the write SHALL win.
REQ-018 l2_mem_wdata SHALL be 0 except during a SERVE_D write.
REQ-019 When l2_mem_resp is 1 in SERVE_x, the block SHALL capture l2_mem_rdata into the granted side's rdata register (reads only) and go to RESP.
- l2_mem_resp outside SERVE_x SHALL be ignored.
REQ-020 In RESP, the granted requester's *_mem_resp SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-021 i_mem_rdata and d_mem_rdata SHALL be registered and SHALL hold their last captured value between transactions.
REQ-022 Latency: request seen in IDLE at cycle N -> L2 request at N+1 -> l2_mem_resp at cycle M -> requester resp at M+1.
- Minimum request-to-resp latency SHALL be 2 cycles.
REQ-023 A requester that drops its request mid-transaction SHALL still receive its resp pulse.
REQ-024 arb_conflict_count SHALL increment on each IDLE grant made with both requests active, and SHALL saturate at 16'hFFFF.

Reset
REQ-025 While reset_n is 0 at a rising edge, the block SHALL set:
- state = IDLE; last_grant = D, so the i-cache wins the first tie;
- all outputs, latched registers and rdata registers = 0; arb_conflict_count = 0.
REQ-026 On reset during SERVE_x or RESP, the block SHALL abandon the transaction: L2 read/write deasserted from the next cycle, no resp pulse.

Structure
REQ-027 lc3b_word (16 bit) and lc3b_cache_line (128 bit) SHALL come from lc3b_types; the state enum and the grant encoding SHALL also be added to lc3b_types.
REQ-028 The block SHALL be a single module with no sub-module; state register, latches and counter SHALL all be in l2_arb_sched.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- i_mem_read=1, addr=16'h1230; L2 resp after 3 cycles with rdata=128'hA5.. -> l2_mem_read=1 at N+1, i_mem_resp for 1 cycle at M+1, i_mem_rdata=128'hA5..; d side unchanged.
- i and d reads asserted together from reset -> I served first, then D; arb_conflict_count=1.
- Back-to-back ties -> grants alternate I,D,I,D; count reaches 4.
- d_mem_write=1, addr=16'h0040, wdata=128'hDEAD.. -> l2_mem_write=1 with latched data; address changed to 16'h0080 mid-transaction -> l2_mem_address stays 16'h0040.
- Reset asserted in SERVE_D -> next cycle all outputs 0, no d_mem_resp; a later i request is served normally.
- 65536 forced conflicts -> counter holds at 16'hFFFF.
